// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline: load-use/RAW stall detection,
// taken-branch squash, in-flight destination scoreboard and saturating stats.
module pipe_hazard_ctrl #(
   parameter bit          FORWARD_EN = 1'b1,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             id_valid_i,
   input  logic [4:0]       id_rs_i,
   input  logic [4:0]       id_rt_i,
   input  logic             id_use_rs_i,
   input  logic             id_use_rt_i,
   input  logic             id_regwrite_i,
   input  logic             id_memread_i,
   input  logic [4:0]       id_dst_i,
   input  logic             mem_branch_taken_i,
   output logic             pc_write_o,
   output logic             ifid_write_o,
   output logic             ifid_flush_o,
   output logic             idex_bubble_o,
   output logic             exmem_flush_o,
   output logic             stall_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o
);

   typedef struct packed {
      logic       valid;
      logic       regwrite;
      logic       memread;
      logic [4:0] dst;
   } sb_entry_t;

   // The WB slot is not held: the register file writes before it reads, so an
   // instruction in WB can never create a hazard and nothing would consume it.
   sb_entry_t sb_ex;
   sb_entry_t sb_mem;
   sb_entry_t id_entry;

   logic taken;
   logic hazard;
   logic rs_used;
   logic rt_used;
   logic ex_hit;
   logic mem_hit;

   function automatic logic hit(input sb_entry_t e, input logic [4:0] r);
      return e.valid && e.regwrite && (e.dst == r) && (r != 5'd0);
   endfunction

   assign taken    = mem_branch_taken_i;
   assign rs_used  = id_valid_i & id_use_rs_i;
   assign rt_used  = id_valid_i & id_use_rt_i;
   assign id_entry = '{valid: id_valid_i, regwrite: id_regwrite_i,
                       memread: id_memread_i, dst: id_dst_i};

   always_comb begin
      ex_hit  = (rs_used & hit(sb_ex, id_rs_i))  | (rt_used & hit(sb_ex, id_rt_i));
      mem_hit = (rs_used & hit(sb_mem, id_rs_i)) | (rt_used & hit(sb_mem, id_rt_i));
      if (FORWARD_EN)
         hazard = ex_hit & sb_ex.memread;
      else
         hazard = ex_hit | mem_hit;
   end

   // A taken branch outranks any stall: the stalled instruction is wrong-path.
   always_comb begin
      pc_write_o    = 1'b1;
      ifid_write_o  = 1'b1;
      ifid_flush_o  = 1'b0;
      idex_bubble_o = 1'b0;
      exmem_flush_o = 1'b0;
      stall_o       = 1'b0;
      if (taken) begin
         ifid_flush_o  = 1'b1;
         idex_bubble_o = 1'b1;
         exmem_flush_o = 1'b1;
      end else if (hazard) begin
         stall_o       = 1'b1;
         pc_write_o    = 1'b0;
         ifid_write_o  = 1'b0;
         idex_bubble_o = 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sb_ex  <= '0;
         sb_mem <= '0;
      end else begin
         sb_mem <= taken ? '0 : sb_ex;
         sb_ex  <= (taken || hazard) ? '0 : id_entry;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         stall_cnt_o <= '0;
         flush_cnt_o <= '0;
      end else begin
         if (stall_o && (stall_cnt_o != '1))
            stall_cnt_o <= stall_cnt_o + CNT_W'(1);
         if (taken && (flush_cnt_o != '1))
            flush_cnt_o <= flush_cnt_o + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic       vld;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       use_rs;
    logic       use_rt;
    logic       rw;
    logic       mr;
    logic [4:0] dst;
    logic       taken;
  } in_t;

  typedef struct {
    string       name;
    int          inst;
    logic [5:0]  ctrl;
    int unsigned scnt;
    int unsigned fcnt;
  } exp_t;

  localparam logic [5:0] NORM  = 6'b110000;
  localparam logic [5:0] STALL = 6'b000101;
  localparam logic [5:0] TAKEN = 6'b111110;
  localparam int unsigned WATCHDOG_NS = 100000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  in_t  in0 = '0;
  in_t  in1 = '0;
  in_t  in2 = '0;

  logic [5:0]  ctrl0, ctrl1, ctrl2;
  logic [15:0] scnt0, fcnt0, scnt1, fcnt1;
  logic [3:0]  scnt2, fcnt2;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic done     = 1'b0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.FORWARD_EN(1'b1), .CNT_W(16)) u_fwd (
    .clk_i(clk), .rst_i(rst),
    .id_valid_i(in0.vld), .id_rs_i(in0.rs), .id_rt_i(in0.rt),
    .id_use_rs_i(in0.use_rs), .id_use_rt_i(in0.use_rt),
    .id_regwrite_i(in0.rw), .id_memread_i(in0.mr), .id_dst_i(in0.dst),
    .mem_branch_taken_i(in0.taken),
    .pc_write_o(ctrl0[5]), .ifid_write_o(ctrl0[4]), .ifid_flush_o(ctrl0[3]),
    .idex_bubble_o(ctrl0[2]), .exmem_flush_o(ctrl0[1]), .stall_o(ctrl0[0]),
    .stall_cnt_o(scnt0), .flush_cnt_o(fcnt0));

  pipe_hazard_ctrl #(.FORWARD_EN(1'b0), .CNT_W(16)) u_nof (
    .clk_i(clk), .rst_i(rst),
    .id_valid_i(in1.vld), .id_rs_i(in1.rs), .id_rt_i(in1.rt),
    .id_use_rs_i(in1.use_rs), .id_use_rt_i(in1.use_rt),
    .id_regwrite_i(in1.rw), .id_memread_i(in1.mr), .id_dst_i(in1.dst),
    .mem_branch_taken_i(in1.taken),
    .pc_write_o(ctrl1[5]), .ifid_write_o(ctrl1[4]), .ifid_flush_o(ctrl1[3]),
    .idex_bubble_o(ctrl1[2]), .exmem_flush_o(ctrl1[1]), .stall_o(ctrl1[0]),
    .stall_cnt_o(scnt1), .flush_cnt_o(fcnt1));

  pipe_hazard_ctrl #(.FORWARD_EN(1'b0), .CNT_W(4)) u_sat (
    .clk_i(clk), .rst_i(rst),
    .id_valid_i(in2.vld), .id_rs_i(in2.rs), .id_rt_i(in2.rt),
    .id_use_rs_i(in2.use_rs), .id_use_rt_i(in2.use_rt),
    .id_regwrite_i(in2.rw), .id_memread_i(in2.mr), .id_dst_i(in2.dst),
    .mem_branch_taken_i(in2.taken),
    .pc_write_o(ctrl2[5]), .ifid_write_o(ctrl2[4]), .ifid_flush_o(ctrl2[3]),
    .idex_bubble_o(ctrl2[2]), .exmem_flush_o(ctrl2[1]), .stall_o(ctrl2[0]),
    .stall_cnt_o(scnt2), .flush_cnt_o(fcnt2));

  task automatic sample(input int inst, output logic [5:0] a_ctrl,
                        output int unsigned a_s, output int unsigned a_f);
    case (inst)
      0:       begin a_ctrl = ctrl0; a_s = 32'(scnt0); a_f = 32'(fcnt0); end
      1:       begin a_ctrl = ctrl1; a_s = 32'(scnt1); a_f = 32'(fcnt1); end
      default: begin a_ctrl = ctrl2; a_s = 32'(scnt2); a_f = 32'(fcnt2); end
    endcase
  endtask

  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t        e;
      logic [5:0]  a_ctrl;
      int unsigned a_s;
      int unsigned a_f;
      e = q.pop_front();
      sample(e.inst, a_ctrl, a_s, a_f);
      n_checks++;
      if (a_ctrl !== e.ctrl || a_s != e.scnt || a_f != e.fcnt) begin
        n_fail++;
        $display("FAIL %s inst%0d: ctrl=%b stall_cnt=%0d flush_cnt=%0d, required ctrl=%b stall_cnt=%0d flush_cnt=%0d",
                 e.name, e.inst, a_ctrl, a_s, a_f, e.ctrl, e.scnt, e.fcnt);
      end
    end
  end

  initial begin
    #(WATCHDOG_NS);
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL watchdog: stimulus did not complete within %0d ns", WATCHDOG_NS);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
    end
  end

  task automatic chk(input string name, input int inst, input logic [5:0] ctrl,
                     input int unsigned scnt, input int unsigned fcnt);
    exp_t e;
    e.name = name; e.inst = inst; e.ctrl = ctrl; e.scnt = scnt; e.fcnt = fcnt;
    q.push_back(e);
  endtask

  task automatic chk_now(input string name, input int inst, input logic [5:0] ctrl,
                         input int unsigned scnt, input int unsigned fcnt);
    logic [5:0]  a_ctrl;
    int unsigned a_s;
    int unsigned a_f;
    sample(inst, a_ctrl, a_s, a_f);
    n_checks++;
    if (a_ctrl !== ctrl || a_s != scnt || a_f != fcnt) begin
      n_fail++;
      $display("FAIL %s inst%0d (immediate): ctrl=%b stall_cnt=%0d flush_cnt=%0d, required ctrl=%b stall_cnt=%0d flush_cnt=%0d",
               name, inst, a_ctrl, a_s, a_f, ctrl, scnt, fcnt);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic in_t instr(input logic [4:0] rs, input logic use_rs,
                                input logic [4:0] rt, input logic use_rt,
                                input logic rw, input logic mr,
                                input logic [4:0] dst, input logic taken);
    in_t v;
    v = '{vld: 1'b1, rs: rs, rt: rt, use_rs: use_rs, use_rt: use_rt,
          rw: rw, mr: mr, dst: dst, taken: taken};
    return v;
  endfunction

  initial begin
    int unsigned stalls;
    #1;
    chk_now("reset_async_fwd", 0, NORM, 0, 0);
    @(posedge clk); #1;
    chk("reset_fwd", 0, NORM, 0, 0);
    chk("reset_nof", 1, NORM, 0, 0);
    chk("reset_sat", 2, NORM, 0, 0);
    tick();
    rst = 1'b0;

    in0 = instr(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0);
    chk("lw_issue", 0, NORM, 0, 0); tick();
    in0 = instr(5'd8, 1'b1, 5'd9, 1'b1, 1'b1, 1'b0, 5'd10, 1'b0);
    chk("loaduse_stall", 0, STALL, 0, 0); tick();
    chk("loaduse_release", 0, NORM, 1, 0); tick();
    in0 = instr(5'd10, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0);
    chk("alu_fwd_nostall", 0, NORM, 1, 0); tick();
    in0 = instr(5'd5, 1'b0, 5'd6, 1'b1, 1'b1, 1'b1, 5'd12, 1'b0);
    chk("unused_rs_nostall", 0, NORM, 1, 0); tick();
    in0 = instr(5'd12, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 5'd13, 1'b1);
    chk("branch_over_stall", 0, TAKEN, 1, 0); tick();
    in0 = instr(5'd12, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    chk("post_branch_ex_empty", 0, NORM, 1, 1); tick();
    in0 = '0;

    in1 = instr(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd9, 1'b0);
    chk("addi_issue", 1, NORM, 0, 0); tick();
    in1 = instr(5'd3, 1'b1, 5'd9, 1'b1, 1'b1, 1'b0, 5'd4, 1'b0);
    chk("raw_stall_ex", 1, STALL, 0, 0); tick();
    chk("raw_stall_mem", 1, STALL, 1, 0); tick();
    chk("raw_release", 1, NORM, 2, 0); tick();
    in1 = instr(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
    chk("addi_r0_issue", 1, NORM, 2, 0); tick();
    in1 = instr(5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 5'd11, 1'b0);
    chk("r0_nostall", 1, NORM, 2, 0); tick();
    in1 = instr(5'd0, 1'b0, 5'd11, 1'b1, 1'b1, 1'b0, 5'd14, 1'b1);
    chk("nof_branch", 1, TAKEN, 2, 0); tick();
    in1 = instr(5'd11, 1'b1, 5'd14, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    chk("post_branch_mem_empty", 1, NORM, 2, 1); tick();
    in1 = '0;
    chk("nof_idle", 1, NORM, 2, 1); tick();

    in0 = instr(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0);
    chk("pre_reset_lw", 0, NORM, 1, 1); tick();
    in0 = instr(5'd8, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 5'd10, 1'b0);
    rst = 1'b1;
    #1;
    chk_now("midreset_async_fwd", 0, NORM, 0, 0);
    chk("midreset_fwd", 0, NORM, 0, 0);
    chk("midreset_nof", 1, NORM, 0, 0);
    tick();
    rst = 1'b0;
    chk("post_reset_nostall", 0, NORM, 0, 0); tick();
    in0 = '0;

    in2 = instr(5'd9, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 5'd9, 1'b0);
    for (int unsigned k = 0; k < 30; k++) begin
      stalls = (k / 3) * 2 + ((k % 3 == 2) ? 1 : 0);
      chk("sat_cycle", 2, (k % 3 == 0) ? NORM : STALL,
          (stalls > 15) ? 15 : stalls, 0);
      tick();
    end
    in2 = '0;

    @(negedge clk);
    #1;
    done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Hazard controller for the 5-stage pipelined CPU (IF/ID/EX/MEM/WB). It sequences the pipeline registers, PC write enable and flushes. It keeps a 3-entry scoreboard of in-flight destination registers (EX, MEM, WB), detects data hazards for the instruction in ID, and squashes wrong-path instructions when a branch resolves taken in MEM. It also keeps saturating stall/flush statistics counters.

Parameters:
FORWARD_EN, 1, 1 = forwarding unit present, so stall only on load-use; 0 = stall on any RAW hit in EX or MEM.
CNT_W, 16, width of the statistics counters.

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous, active-high reset
id_valid_i  input  1  ID stage holds a real instruction
id_rs_i  input  5  rs field of the ID instruction
id_rt_i  input  5  rt field of the ID instruction
id_use_rs_i  input  1  ID instruction reads rs
id_use_rt_i  input  1  ID instruction reads rt
id_regwrite_i  input  1  RegWrite from the decoder
id_memread_i  input  1  MemRead from the decoder (load)
id_dst_i  input  5  final destination register (after RegDst mux)
mem_branch_taken_i  input  1  branch in MEM resolved taken this cycle
pc_write_o  output  1  PC update enable
ifid_write_o  output  1  IF/ID register write enable
ifid_flush_o  output  1  clear IF/ID to a NOP
idex_bubble_o  output  1  load a NOP into ID/EX
exmem_flush_o  output  1  load a NOP into EX/MEM
stall_o  output  1  hazard stall active this cycle
stall_cnt_o  output  CNT_W  total stall cycles, saturating
flush_cnt_o  output  CNT_W  total taken-branch flush events, saturating

Behaviour:
- Scoreboard entry = {valid, regwrite, memread, dst[4:0]}; slots SB_EX, SB_MEM, SB_WB.
- Reset (async, rst_i=1): all scoreboard entries cleared to 0; both counters 0. With an empty scoreboard and mem_branch_taken_i=0, outputs are pc_write_o=1, ifid_write_o=1, all others 0.
- Hit(slot, r): slot.valid & slot.regwrite & slot.dst==r & r!=0. An operand counts only if id_valid_i and its id_use_* bit is set.
- Hazard, FORWARD_EN=1: Hit(SB_EX, operand) & SB_EX.memread.
- Hazard, FORWARD_EN=0: Hit(SB_EX, operand) | Hit(SB_MEM, operand). SB_WB never causes a hazard, because the register file writes before it reads.
- Control outputs are combinational in the same cycle:
  - taken = mem_branch_taken_i.
  - If taken: ifid_flush_o=1, idex_bubble_o=1, exmem_flush_o=1, pc_write_o=1, ifid_write_o=1, stall_o=0. Branch has priority over any stall.
  - Else if hazard: stall_o=1, pc_write_o=0, ifid_write_o=0, idex_bubble_o=1, flushes=0.
  - Else: pc_write_o=1, ifid_write_o=1, others 0.
- Scoreboard shift on every rising edge: SB_WB<=SB_MEM.
  - SB_MEM<=0 if taken, else SB_EX.
  - SB_EX<=0 if taken or hazard, else the ID info {id_valid_i, id_regwrite_i, id_memread_i, id_dst_i}.
- Counters:
  - stall_cnt_o increments by 1 on each edge where stall_o=1.
  - flush_cnt_o increments by 1 on each edge where taken=1.
  - Both hold at all-ones (saturate, no wrap).
- Load-use with FORWARD_EN=1 costs exactly 1 stall cycle. The next cycle SB_EX is a bubble and the load sits in SB_MEM, which forwarding covers.
- With FORWARD_EN=0, a dependency on the immediately preceding instruction stalls 2 cycles.
- Taken branch inserts 3 bubbles (IF, ID, EX squashed).
- Reset mid-operation: scoreboard and counters clear immediately; no pending stall survives.

Test Plan:
1. Reset with rst_i=1 mid-stream → scoreboard empty, pc_write_o=1, ifid_write_o=1, stall_o=0, stall_cnt_o=0, flush_cnt_o=0 with no clock edge needed.
2. FORWARD_EN=1: lw dst=8, then add rs=8 in ID → stall_o=1, pc_write_o=0, idex_bubble_o=1 for exactly 1 cycle, then normal flow; stall_cnt_o=1.
3. FORWARD_EN=0: addi dst=9, then sub rt=9 → stall_o=1 for 2 consecutive cycles; stall_cnt_o=2. Repeat with dst=0 → no stall.
4. Load-use hazard present in the same cycle as mem_branch_taken_i=1 → ifid_flush_o=idex_bubble_o=exmem_flush_o=1, pc_write_o=1, stall_o=0; next cycle SB_EX and SB_MEM invalid; flush_cnt_o=1, stall_cnt_o unchanged.
5. FORWARD_EN=1: non-load writer dst=5 in EX, ID reads rs=5 → no stall. Same with the ID instruction having id_use_rs_i=0 and the EX instruction a load → no stall.
6. Force a continuous hazard for 2^CNT_W+3 cycles → stall_cnt_o saturates at all-ones (0xFFFF for CNT_W=16) and holds.
